// File: rtl/cs_accumulator_multichannel_if.sv
// Command/result bundle of the multi-channel carry-save accumulator.
// The producer side drives the operand and commands. The accumulator side returns the resolved result and status.
interface cs_accumulator_multichannel_if #(
   parameter int INPUT_LENGTH  = 16,
   parameter int OUTPUT_LENGTH = 32,
   parameter int CHANNELS      = 4
);
   localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   logic [INPUT_LENGTH-1:0]  iA;
   logic [CH_W-1:0]          iCh;
   logic                     iAccumulate;
   logic                     iTerminate;
   logic [OUTPUT_LENGTH-1:0] oRes;
   logic [CH_W-1:0]          oResCh;
   logic                     oOverflow;
   logic                     oReady;
   logic                     oDone;

   modport master (
      output iA, iCh, iAccumulate, iTerminate,
      input  oRes, oResCh, oOverflow, oReady, oDone
   );

   modport slave (
      input  iA, iCh, iAccumulate, iTerminate,
      output oRes, oResCh, oOverflow, oReady, oDone
   );
endinterface

// File: rtl/cs_accumulator_multichannel.sv
// Holds CHANNELS running sums in redundant sum/carry form and accepts one operand per cycle.
// On terminate, it resolves the selected channel to binary CHUNK_WIDTH bits per cycle and clears the channel.
module cs_accumulator_multichannel #(
   parameter int INPUT_LENGTH  = 16,
   parameter int OUTPUT_LENGTH = 32,
   parameter int CHANNELS      = 4,
   parameter int CHUNK_WIDTH   = 8,
   parameter int SIGNED        = 0
) (
   input logic                          iClk,
   input logic                          iRstN,
   cs_accumulator_multichannel_if.slave bus
);
   localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int NCHUNK = (OUTPUT_LENGTH + CHUNK_WIDTH - 1) / CHUNK_WIDTH;
   localparam int PAD_W  = NCHUNK * CHUNK_WIDTH;
   localparam int LAST_W = OUTPUT_LENGTH - (NCHUNK - 1) * CHUNK_WIDTH;
   localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   typedef enum logic [1:0] {IDLE, RESOLVE, DONE} state_t;

   state_t                   r_state, w_nextState;
   logic [OUTPUT_LENGTH-1:0] r_sum   [CHANNELS];
   logic [OUTPUT_LENGTH-1:0] r_carry [CHANNELS];
   logic [CHANNELS-1:0]      r_ovf;
   logic [OUTPUT_LENGTH-1:0] r_opS, r_opC, r_resPart, r_res;
   logic                     r_opOvf, r_opCmsb, r_chunkCarry, r_overflow;
   logic [CNT_W-1:0]         r_chunk;
   logic [CH_W-1:0]          r_ch, r_resCh;

   logic                     w_chValid, w_doAcc, w_doTerm, w_lastChunk, w_carryOut, w_selOvf;
   logic [OUTPUT_LENGTH-1:0] w_ext, w_selS, w_selC, w_resolved;
   logic [CHUNK_WIDTH-1:0]   w_chunkS, w_chunkC;
   logic [CHUNK_WIDTH:0]     w_chunkSum;

   assign w_chValid = (32'(bus.iCh) < CHANNELS);

   always_comb begin
      w_ext = '0;
      w_ext[INPUT_LENGTH-1:0] = bus.iA;
      for (int i = INPUT_LENGTH; i < OUTPUT_LENGTH; i++)
         w_ext[i] = (SIGNED != 0) && bus.iA[INPUT_LENGTH-1];
   end

   always_comb begin
      w_selS   = '0;
      w_selC   = '0;
      w_selOvf = 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (bus.iCh == CH_W'(c)) begin
            w_selS   = r_sum[c];
            w_selC   = r_carry[c];
            w_selOvf = r_ovf[c];
         end
      end
   end

   // The last chunk may be partial, so its carry-out sits at bit LAST_W of the zero-padded chunk sum.
   always_comb begin
      w_chunkS    = CHUNK_WIDTH'(PAD_W'(r_opS) >> (CHUNK_WIDTH * r_chunk));
      w_chunkC    = CHUNK_WIDTH'(PAD_W'(r_opC) >> (CHUNK_WIDTH * r_chunk));
      w_chunkSum  = {1'b0, w_chunkS} + {1'b0, w_chunkC} + {{CHUNK_WIDTH{1'b0}}, r_chunkCarry};
      w_lastChunk = (r_chunk == CNT_W'(NCHUNK - 1));
      w_carryOut  = w_chunkSum[LAST_W];
      w_resolved  = r_resPart |
                    OUTPUT_LENGTH'(PAD_W'(w_chunkSum[CHUNK_WIDTH-1:0]) << (CHUNK_WIDTH * r_chunk));
   end

   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) r_state <= IDLE;
      else        r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      w_doAcc     = 1'b0;
      w_doTerm    = 1'b0;
      unique case (r_state)
         IDLE: begin
            w_doTerm = bus.iTerminate && w_chValid;
            w_doAcc  = bus.iAccumulate && !bus.iTerminate && w_chValid;
            if (w_doTerm) w_nextState = RESOLVE;
         end
         RESOLVE: if (w_lastChunk) w_nextState = DONE;
         DONE:    w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // A carry bit leaving the MSB carries weight 2^OUTPUT_LENGTH, so in unsigned mode it marks overflow.
   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         for (int c = 0; c < CHANNELS; c++) begin
            r_sum[c]   <= '0;
            r_carry[c] <= '0;
         end
         r_ovf <= '0;
      end else begin
         for (int c = 0; c < CHANNELS; c++) begin
            if (bus.iCh == CH_W'(c)) begin
               if (w_doTerm) begin
                  r_sum[c]   <= '0;
                  r_carry[c] <= '0;
                  r_ovf[c]   <= 1'b0;
               end else if (w_doAcc) begin
                  r_sum[c]   <= w_ext ^ r_sum[c] ^ (r_carry[c] << 1);
                  r_carry[c] <= (w_ext & r_sum[c]) | (w_ext & (r_carry[c] << 1)) |
                                (r_sum[c] & (r_carry[c] << 1));
                  if ((SIGNED == 0) && r_carry[c][OUTPUT_LENGTH-1]) r_ovf[c] <= 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         r_opS        <= '0;
         r_opC        <= '0;
         r_opOvf      <= 1'b0;
         r_opCmsb     <= 1'b0;
         r_ch         <= '0;
         r_chunk      <= '0;
         r_chunkCarry <= 1'b0;
         r_resPart    <= '0;
         r_res        <= '0;
         r_resCh      <= '0;
         r_overflow   <= 1'b0;
      end else if (w_doTerm) begin
         r_opS        <= w_selS;
         r_opC        <= w_selC << 1;
         r_opOvf      <= w_selOvf;
         r_opCmsb     <= w_selC[OUTPUT_LENGTH-1];
         r_ch         <= bus.iCh;
         r_chunk      <= '0;
         r_chunkCarry <= 1'b0;
         r_resPart    <= '0;
      end else if (r_state == RESOLVE) begin
         r_resPart    <= w_resolved;
         r_chunkCarry <= w_chunkSum[CHUNK_WIDTH];
         r_chunk      <= r_chunk + CNT_W'(1);
         if (w_lastChunk) begin
            r_res      <= w_resolved;
            r_resCh    <= r_ch;
            r_overflow <= (SIGNED == 0) && (r_opOvf || r_opCmsb || w_carryOut);
         end
      end
   end

   assign bus.oRes      = r_res;
   assign bus.oResCh    = r_resCh;
   assign bus.oOverflow = r_overflow;
   assign bus.oReady    = (r_state == IDLE);
   assign bus.oDone     = (r_state == DONE);
endmodule

// File: tb/tb_cs_accumulator_multichannel.sv
// Three accumulator variants (32-bit unsigned, 16-bit unsigned with 3 channels, 32-bit signed) share one command stream.
// Each variant is compared every cycle against a plain-integer model of its channel totals.
module tb_cs_accumulator_multichannel;
   localparam int NDUT = 3;

   logic        clock;
   logic        rstN;
   logic [15:0] a;
   logic [1:0]  ch;
   logic        acc, term;
   int          errors, checks;

   cs_accumulator_multichannel_if #(.INPUT_LENGTH(16), .OUTPUT_LENGTH(32), .CHANNELS(4)) bus0 ();
   cs_accumulator_multichannel_if #(.INPUT_LENGTH(16), .OUTPUT_LENGTH(16), .CHANNELS(3)) bus1 ();
   cs_accumulator_multichannel_if #(.INPUT_LENGTH(16), .OUTPUT_LENGTH(32), .CHANNELS(4)) bus2 ();

   assign bus0.iA = a;  assign bus0.iCh = ch;  assign bus0.iAccumulate = acc;  assign bus0.iTerminate = term;
   assign bus1.iA = a;  assign bus1.iCh = ch;  assign bus1.iAccumulate = acc;  assign bus1.iTerminate = term;
   assign bus2.iA = a;  assign bus2.iCh = ch;  assign bus2.iAccumulate = acc;  assign bus2.iTerminate = term;

   cs_accumulator_multichannel #(.INPUT_LENGTH(16), .OUTPUT_LENGTH(32), .CHANNELS(4),
                                 .CHUNK_WIDTH(8), .SIGNED(0)) dut0 (.iClk(clock), .iRstN(rstN), .bus(bus0));
   cs_accumulator_multichannel #(.INPUT_LENGTH(16), .OUTPUT_LENGTH(16), .CHANNELS(3),
                                 .CHUNK_WIDTH(8), .SIGNED(0)) dut1 (.iClk(clock), .iRstN(rstN), .bus(bus1));
   cs_accumulator_multichannel #(.INPUT_LENGTH(16), .OUTPUT_LENGTH(32), .CHANNELS(4),
                                 .CHUNK_WIDTH(12), .SIGNED(1)) dut2 (.iClk(clock), .iRstN(rstN), .bus(bus2));

   logic [31:0] obsRes [NDUT];
   logic [31:0] obsCh  [NDUT];
   logic        obsOvf [NDUT];
   logic        obsReady [NDUT];
   logic        obsDone [NDUT];

   assign obsRes[0] = bus0.oRes;          assign obsRes[1] = 32'(bus1.oRes);   assign obsRes[2] = bus2.oRes;
   assign obsCh[0]  = 32'(bus0.oResCh);   assign obsCh[1]  = 32'(bus1.oResCh); assign obsCh[2]  = 32'(bus2.oResCh);
   assign obsOvf[0] = bus0.oOverflow;     assign obsOvf[1] = bus1.oOverflow;   assign obsOvf[2] = bus2.oOverflow;
   assign obsReady[0] = bus0.oReady;      assign obsReady[1] = bus1.oReady;    assign obsReady[2] = bus2.oReady;
   assign obsDone[0]  = bus0.oDone;       assign obsDone[1]  = bus1.oDone;     assign obsDone[2]  = bus2.oDone;

   // The model keeps exact integer channel totals. mBusy counts the cycles left until the variant is ready again.
   longint      mSum [NDUT][4];
   int          mBusy [NDUT];
   logic [31:0] mPendRes [NDUT], mExpRes [NDUT];
   logic [31:0] mPendCh [NDUT], mExpCh [NDUT];
   logic        mPendOvf [NDUT], mExpOvf [NDUT];

   function automatic int outLen(int d);   return (d == 1) ? 16 : 32; endfunction
   function automatic int chans(int d);    return (d == 1) ? 3 : 4;   endfunction
   function automatic int nChunk(int d);   return (d == 0) ? 4 : ((d == 1) ? 2 : 3); endfunction
   function automatic bit isSigned(int d); return (d == 2); endfunction

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic resetModel();
      for (int d = 0; d < NDUT; d++) begin
         for (int c = 0; c < 4; c++) mSum[d][c] = 0;
         mBusy[d] = 0;
         mPendRes[d] = '0; mExpRes[d] = '0; mPendCh[d] = '0; mExpCh[d] = '0;
         mPendOvf[d] = 1'b0; mExpOvf[d] = 1'b0;
      end
   endtask

   task automatic modelEdge();
      longint mask;
      for (int d = 0; d < NDUT; d++) begin
         mask = (longint'(1) << outLen(d)) - 1;
         if (mBusy[d] > 0) begin
            mBusy[d]--;
            if (mBusy[d] == 1) begin
               mExpRes[d] = mPendRes[d];
               mExpCh[d]  = mPendCh[d];
               mExpOvf[d] = mPendOvf[d];
            end
         end else if (int'(ch) < chans(d)) begin
            if (term) begin
               mPendRes[d] = 32'(mSum[d][ch] & mask);
               mPendOvf[d] = !isSigned(d) && (mSum[d][ch] > mask);
               mPendCh[d]  = 32'(ch);
               mSum[d][ch] = 0;
               mBusy[d]    = nChunk(d) + 1;
            end else if (acc) begin
               mSum[d][ch] += isSigned(d) ? longint'($signed(a)) : longint'(a);
            end
         end
      end
   endtask

   task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic checkOutput();
      for (int d = 0; d < NDUT; d++) begin
         checkVal($sformatf("ready%0d", d), 32'(obsReady[d]), 32'(mBusy[d] == 0));
         checkVal($sformatf("done%0d", d), 32'(obsDone[d]), 32'(mBusy[d] == 1));
         checkVal($sformatf("res%0d", d), obsRes[d], mExpRes[d]);
         checkVal($sformatf("resCh%0d", d), obsCh[d], mExpCh[d]);
         checkVal($sformatf("ovf%0d", d), 32'(obsOvf[d]), 32'(mExpOvf[d]));
      end
   endtask

   task automatic applyStimulus(input logic [15:0] va, input logic [1:0] vch, input logic vacc, input logic vterm);
      a = va; ch = vch; acc = vacc; term = vterm;
      @(posedge clock);
      modelEdge();
      #1;
      checkOutput();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(16'h0000, 2'd0, 1'b0, 1'b0);
   endtask

   initial begin
      errors = 0; checks = 0;
      a = '0; ch = '0; acc = 1'b0; term = 1'b0; rstN = 1'b1;
      #2 rstN = 1'b0;
      #1 resetModel();
      checkOutput();
      repeat (2) @(posedge clock);
      #1 rstN = 1'b1;

      $display("[TB] basic sum");
      applyStimulus(16'h1234, 2'd0, 1'b1, 1'b0);
      applyStimulus(16'h0001, 2'd0, 1'b1, 1'b0);
      applyStimulus(16'hFFFF, 2'd0, 1'b1, 1'b0);
      applyStimulus(16'h0000, 2'd0, 1'b0, 1'b1);
      idle(4);
      checkVal("basicDone", 32'(obsDone[0]), 32'd1);
      checkVal("basicRes", obsRes[0], 32'h00011234);
      checkVal("basicOvf", 32'(obsOvf[0]), 32'd0);
      idle(2);
      applyStimulus(16'h0000, 2'd0, 1'b0, 1'b1);
      idle(6);
      checkVal("reTermRes", obsRes[0], 32'h0);

      $display("[TB] channel isolation");
      applyStimulus(16'd10, 2'd1, 1'b1, 1'b0);
      applyStimulus(16'd5,  2'd2, 1'b1, 1'b0);
      applyStimulus(16'd20, 2'd1, 1'b1, 1'b0);
      applyStimulus(16'd0,  2'd1, 1'b0, 1'b1);
      idle(6);
      checkVal("isoCh1", obsRes[0], 32'd30);
      checkVal("isoCh1Id", obsCh[0], 32'd1);
      applyStimulus(16'd0, 2'd2, 1'b0, 1'b1);
      idle(6);
      checkVal("isoCh2", obsRes[0], 32'd5);
      applyStimulus(16'd0, 2'd3, 1'b0, 1'b1);
      idle(6);
      checkVal("isoCh3", obsRes[0], 32'd0);

      $display("[TB] unsigned overflow");
      applyStimulus(16'hFFFF, 2'd0, 1'b1, 1'b0);
      applyStimulus(16'hFFFF, 2'd0, 1'b1, 1'b0);
      applyStimulus(16'h0000, 2'd0, 1'b0, 1'b1);
      idle(6);
      checkVal("ovfRes16", obsRes[1], 32'h0000FFFE);
      checkVal("ovfFlag16", 32'(obsOvf[1]), 32'd1);
      applyStimulus(16'h0000, 2'd0, 1'b0, 1'b1);
      idle(6);
      checkVal("ovfClrRes16", obsRes[1], 32'h0);
      checkVal("ovfClrFlag16", 32'(obsOvf[1]), 32'd0);

      $display("[TB] signed mode");
      applyStimulus(16'hFFFD, 2'd0, 1'b1, 1'b0);
      applyStimulus(16'h0005, 2'd0, 1'b1, 1'b0);
      applyStimulus(16'h0000, 2'd0, 1'b0, 1'b1);
      idle(6);
      checkVal("signedSum", obsRes[2], 32'h00000002);
      checkVal("signedOvf", 32'(obsOvf[2]), 32'd0);
      applyStimulus(16'hFFF9, 2'd1, 1'b1, 1'b0);
      applyStimulus(16'h0000, 2'd1, 1'b0, 1'b1);
      idle(6);
      checkVal("signedNeg", obsRes[2], 32'hFFFFFFF9);

      $display("[TB] collisions");
      applyStimulus(16'd7, 2'd0, 1'b1, 1'b0);
      applyStimulus(16'd9, 2'd0, 1'b1, 1'b1);
      idle(6);
      checkVal("termPriority", obsRes[0], 32'd7);
      applyStimulus(16'd0,   2'd1, 1'b0, 1'b1);
      applyStimulus(16'd100, 2'd1, 1'b1, 1'b0);
      idle(6);
      applyStimulus(16'd0, 2'd1, 1'b0, 1'b1);
      idle(6);
      checkVal("accDuringResolve", obsRes[0], 32'd0);
      applyStimulus(16'd5, 2'd3, 1'b1, 1'b0);
      applyStimulus(16'd0, 2'd3, 1'b0, 1'b1);
      checkVal("badChReady", 32'(obsReady[1]), 32'd1);
      checkVal("goodChBusy", 32'(obsReady[0]), 32'd0);
      idle(6);

      $display("[TB] async reset mid-resolve");
      applyStimulus(16'h0055, 2'd0, 1'b1, 1'b0);
      applyStimulus(16'h0000, 2'd0, 1'b0, 1'b1);
      idle(1);
      #2 rstN = 1'b0;
      #1 resetModel();
      checkOutput();
      checkVal("rstReady", 32'(obsReady[0]), 32'd1);
      checkVal("rstDone", 32'(obsDone[0]), 32'd0);
      @(posedge clock);
      #1 rstN = 1'b1;
      checkOutput();
      applyStimulus(16'h0000, 2'd0, 1'b0, 1'b1);
      idle(6);
      checkVal("postRstRes", obsRes[0], 32'd0);

      $display("[TB] random traffic");
      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom),
                       2'($urandom_range(0, 3)),
                       1'($urandom_range(0, 3) != 0),
                       1'($urandom_range(0, 9) == 0));
      end
      for (int c = 0; c < 4; c++) begin
         applyStimulus(16'h0000, 2'(c), 1'b0, 1'b1);
         idle(6);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/cs_accumulator_multichannel.md
# cs_accumulator_multichannel

Multi-channel carry-save accumulator, successor to the single-channel carry-save accumulator in the fast-arithmetic library. It holds `CHANNELS` independent running sums in redundant sum/carry form, so any channel can absorb one operand per cycle with no carry propagation. Each channel supports signed or unsigned operands and a sticky unsigned-overflow flag. On terminate, the selected channel's sum and carry vectors are resolved into a binary result by a chunked internal adder, `CHUNK_WIDTH` bits per cycle, and the channel is cleared. The block sits between datapath producers (e.g. partial-product generators) and consumers that need binary totals.

## Interface
- `INPUT_LENGTH`, 16, operand width.
- `OUTPUT_LENGTH`, 32, accumulator/result width; must be ≥ `INPUT_LENGTH`.
- `CHANNELS`, 4, number of independent accumulators; must be ≥ 1.
- `CHUNK_WIDTH`, 8, bits resolved per cycle; `NCHUNK = ceil(OUTPUT_LENGTH/CHUNK_WIDTH)`.
- `SIGNED`, 0, 1 = sign-extend `iA` (two's complement), 0 = zero-extend.
- `iClk` in 1: single clock, rising edge.
- `iRstN` in 1: reset, asynchronous, active-low.
- `iA` in `INPUT_LENGTH`: operand.
- `iCh` in `CH_W = max(1, $clog2(CHANNELS))`: channel select for accumulate and terminate.
- `iAccumulate` in 1: add `iA` to channel `iCh`.
- `iTerminate` in 1: resolve channel `iCh`, return its sum, clear it.
- `oRes` out `OUTPUT_LENGTH`: last resolved result, held until the next result.
- `oResCh` out `CH_W`: channel that produced `oRes`.
- `oOverflow` out 1: overflow status for `oRes` (unsigned mode only).
- `oReady` out 1: commands are accepted this cycle.
- `oDone` out 1: one-cycle pulse when `oRes` is newly valid.

## Operation
- **Storage.** Per channel: sum vector `S[c]` and carry vector `C[c]`, each `OUTPUT_LENGTH` bits, plus sticky `OVF[c]`. Represented value is `V = S + (C<<1) mod 2^OUTPUT_LENGTH`.
- **FSM.** States IDLE, RESOLVE, DONE. `oReady = (state == IDLE)`.
- **Accumulate.** Accepted when in IDLE, `iAccumulate=1`, `iTerminate=0`, and `iCh < CHANNELS`.
  - Let `E` = `iA` extended to `OUTPUT_LENGTH` (sign- or zero-extended per `SIGNED`).
  - `S' = E ^ S ^ (C<<1)`; `C' = maj(E, S, C<<1)`, bitwise.
  - If `SIGNED=0` and `C[OUTPUT_LENGTH-1]=1` before the update, set `OVF`. This is the discarded 2^N weight.
  - Other channels are untouched.
- **Terminate.** Accepted when in IDLE, `iTerminate=1`, and `iCh < CHANNELS`. Terminate has priority over a simultaneous `iAccumulate`; that operand is dropped.
  - Copy `S`, `C<<1`, `OVF`, and `C[MSB]` into working registers. Record the channel.
  - Clear the channel's `S`, `C`, and `OVF` to 0.
  - Go to RESOLVE with chunk counter = 0.
- **RESOLVE.** Each cycle, add chunk k of the two operands plus the carry from chunk k−1 (carry-in 0 for chunk 0), and store the chunk result. The final chunk may be partial. After chunk `NCHUNK−1`, go to DONE.
- **DONE.** Lasts one cycle.
  - `oRes` = resolved sum; `oResCh` = recorded channel.
  - `oOverflow` = copied `OVF` | copied `C[MSB]` | final carry-out, when `SIGNED=0`. It is always 0 when `SIGNED=1`.
  - `oDone=1`. Next state is IDLE.
- **Ignored commands.** Any command in RESOLVE or DONE is ignored with no side effects. A command with `iCh ≥ CHANNELS` is ignored.
- **Wrap-around.** Results are modulo `2^OUTPUT_LENGTH` in both modes.

## Timing
- **Reset.** When `iRstN` is low, the following clear immediately with no clock: state=IDLE, all `S`/`C`/`OVF`=0, working registers=0, `oRes`=0, `oResCh`=0, `oOverflow`=0, `oDone`=0, `oReady`=1.
- **Accumulate latency.** An accumulate accepted at edge k is visible in the channel state after edge k. Back-to-back accumulates (any channels) are accepted every cycle at full throughput.
- **Terminate latency.** For a terminate accepted at edge k:
  - RESOLVE occupies edges k+1 … k+`NCHUNK`.
  - DONE holds in the cycle after edge k+`NCHUNK`: `oDone=1`, `oRes`/`oResCh`/`oOverflow` valid and held until the next DONE.
  - `oReady` is 0 from edge k until edge k+`NCHUNK`+1.
- **Post-terminate accumulate.** An accumulate to the channel at edge k+`NCHUNK`+1 starts from 0.
- **Reset mid-RESOLVE.** Aborts the resolution. No `oDone` pulse; all channels read 0 afterwards.

## Test plan
- **Basic sum.** Defaults. Reset, then accumulate ch0: `0x1234`, `0x0001`, `0xFFFF` on consecutive cycles; terminate ch0 → `oDone` 5 cycles after the terminate edge (4 RESOLVE + DONE), `oRes=0x00011234`, `oResCh=0`, `oOverflow=0`. Terminate ch0 again → `oRes=0`.
- **Channel isolation.** ch1 += 10, 20; ch2 += 5, interleaved; terminate ch1 → 30; terminate ch2 → 5; terminate ch3 → 0.
- **Unsigned overflow.** `OUTPUT_LENGTH=16`, `CHUNK_WIDTH=8`. Accumulate `0xFFFF` twice on ch0, terminate → `oRes=0xFFFE`, `oOverflow=1`. Re-terminate ch0 → `oRes=0`, `oOverflow=0`.
- **Signed mode.** `SIGNED=1`. ch0 += `0xFFFD` (−3), `0x0005` → `oRes=0x00000002`, `oOverflow=0`. ch1 += `0xFFF9` → `oRes=0xFFFFFFF9`.
- **Collisions.**
  - `iAccumulate` and `iTerminate` together on ch0 holding 7, `iA=9` → `oRes=7`.
  - `iAccumulate` during RESOLVE is ignored.
  - With `CHANNELS=3`, `iCh=3` commands are ignored: `oReady` stays 1 and no `oDone`.
- **Async reset.** Accumulate 0x55 on ch0, terminate, then drop `iRstN` in the 2nd RESOLVE cycle between edges → outputs clear immediately, `oReady=1`, no `oDone`. A subsequent terminate of ch0 returns 0.
